// File: rtl/l1_sum_unpacker_pkg.sv
// Shared definitions for the L1 sum unpacker: logic levels, FSM state
// encoding and the lane width derived from the upstream adder width.
package l1_sum_unpacker_pkg;

    localparam logic high_val = 1'b1;
    localparam logic low_val  = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // An adder of data_width operands produces a data_width+1 bit sum.
    function automatic int lane_width_of(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/l1_sum_unpacker_if.sv
// Packed-vector input handshake and per-lane output stream of the L1
// sum unpacker; slave is the unpacker, master is the surrounding logic.
interface l1_sum_unpacker_if
    import l1_sum_unpacker_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int array_size     = 8,
    parameter int lane_idx_width = 3
);

    logic                                        in_valid;
    logic                                        in_ready;
    logic [(data_width*array_size)+array_size-1:0] in_data;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [lane_width_of(data_width)-1:0]        out_data;
    logic [lane_idx_width-1:0]                   out_lane;
    logic                                        out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );

endinterface

// File: rtl/l1_lane_select.sv
// Combinational array_size:1 selector of fixed-width lanes from a packed
// vector; shared by the L1/L2 unpackers.
module l1_lane_select #(
    parameter int lane_width = 17,
    parameter int array_size = 8,
    parameter int sel_width  = 3
) (
    input  logic [lane_width*array_size-1:0] lanes,
    input  logic [sel_width-1:0]             sel,
    output logic [lane_width-1:0]            lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < array_size; i++) begin
            if (sel == sel_width'(i)) begin
                lane = lanes[i*lane_width +: lane_width];
            end
        end
    end

endmodule

// File: rtl/l1_sum_unpacker.sv
// Captures one packed vector of L1 lane sums and replays it lane 0 first,
// one lane per accepted beat, to the next accumulation stage.
module l1_sum_unpacker
    import l1_sum_unpacker_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int array_size     = 8,
    parameter int lane_idx_width = 3
) (
    input  logic              clk,
    input  logic              reset,
    l1_sum_unpacker_if.slave  bus
);

    localparam int lane_width = lane_width_of(data_width);
    localparam int vec_width  = lane_width * array_size;
    localparam logic [lane_idx_width-1:0] last_lane = lane_idx_width'(array_size - 1);

    state_t                    state;
    state_t                    state_next;
    logic [lane_idx_width-1:0] lane_cnt;
    logic [vec_width-1:0]      buffer;
    logic                      last_beat;
    logic                      capture;
    logic                      advance;
    logic                      finish;

    assign last_beat = (lane_cnt == last_lane);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        capture       = low_val;
        advance       = low_val;
        finish        = low_val;
        bus.in_ready  = low_val;
        bus.out_valid = low_val;
        bus.out_last  = low_val;
        case (state)
            IDLE: begin
                bus.in_ready = high_val;
                if (bus.in_valid) begin
                    capture    = high_val;
                    state_next = SEND;
                end
            end
            SEND: begin
                bus.out_valid = high_val;
                bus.out_last  = last_beat;
                if (bus.out_ready) begin
                    if (last_beat) begin
                        finish     = high_val;
                        state_next = IDLE;
                    end else begin
                        advance = high_val;
                    end
                end
            end
        endcase
    end

    // NOTE: the buffer is small and its reset value is observable on out_data,
    // so it is reset along with the control state rather than left undefined.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt <= '0;
            buffer   <= '0;
        end else if (capture) begin
            lane_cnt <= '0;
            buffer   <= bus.in_data;
        end else if (advance) begin
            lane_cnt <= lane_cnt + 1'b1;
        end else if (finish) begin
            lane_cnt <= '0;
        end
    end

    l1_lane_select #(
        .lane_width (lane_width),
        .array_size (array_size),
        .sel_width  (lane_idx_width)
    ) u_lane_select (
        .lanes (buffer),
        .sel   (lane_cnt),
        .lane  (bus.out_data)
    );

    assign bus.out_lane = lane_cnt;

endmodule

// File: tb/tb_l1_sum_unpacker.sv
// Directed self-checking bench for l1_sum_unpacker: drives at the falling
// edge and samples at the falling edge, away from the active rising edge.
module tb_l1_sum_unpacker;

    localparam int DW = 16;
    localparam int AS = 8;
    localparam int IW = 3;
    localparam int LW = DW + 1;
    localparam int VW = LW * AS;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   beat_total;

    logic [VW-1:0] vec_seq;
    logic [VW-1:0] vec_ones;
    logic [VW-1:0] vec_alt;

    l1_sum_unpacker_if #(.data_width(DW), .array_size(AS), .lane_idx_width(IW)) bus ();

    l1_sum_unpacker #(.data_width(DW), .array_size(AS), .lane_idx_width(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a vector at the current falling edge; returns at the next one.
    task automatic offer(input string tag, input logic [VW-1:0] vec);
        bus.in_valid = 1'b1;
        bus.in_data  = vec;
        check($sformatf("%s offer in_ready", tag), 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    // Drain one vector with a per-cycle stall mask, tracking the expected
    // lane independently, then confirm the idle cycle that follows.
    task automatic run_drain(input string tag, input logic [VW-1:0] vec,
                             input logic [31:0] stall_mask, input bit keep_valid,
                             input int exp_cycles);
        int c;
        int lane;
        c    = 0;
        lane = 0;
        while (lane < AS && c < 32) begin
            if (c == 0) bus.in_valid = keep_valid;
            bus.out_ready = ~stall_mask[c];
            check($sformatf("%s c%0d out_valid", tag, c), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s c%0d out_lane", tag, c), 32'(bus.out_lane), 32'(lane));
            check($sformatf("%s c%0d out_data", tag, c), 32'(bus.out_data), 32'(vec[lane*LW +: LW]));
            check($sformatf("%s c%0d out_last", tag, c), 32'(bus.out_last), 32'(lane == AS - 1));
            check($sformatf("%s c%0d in_ready", tag, c), 32'(bus.in_ready), 32'd0);
            if (bus.out_ready) begin
                lane++;
                beat_total++;
            end
            c++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        check($sformatf("%s drain cycles", tag), 32'(c), 32'(exp_cycles));
        check($sformatf("%s idle in_ready", tag), 32'(bus.in_ready), 32'd1);
        check($sformatf("%s idle out_valid", tag), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s idle out_lane", tag), 32'(bus.out_lane), 32'd0);
        check($sformatf("%s idle out_last", tag), 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        int start_cyc;
        checks        = 0;
        errors        = 0;
        beat_total    = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < AS; i++) begin
            vec_seq[i*LW +: LW]  = LW'(i + 1);
            vec_ones[i*LW +: LW] = 17'h1FFFF;
            vec_alt[i*LW +: LW]  = (i % 2 == 0) ? 17'h1FFFF : 17'h10000;
        end

        // Reset values while reset is held low.
        @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_lane", 32'(bus.out_lane), 32'd0);
        check("rst out_last", 32'(bus.out_last), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic drain: lanes 1..8, no stalls.
        offer("basic", vec_seq);
        run_drain("basic", vec_seq, 32'h0, 1'b0, 8);

        // Backpressure on the 2nd and 6th valid cycles holds lanes 1 and 4.
        offer("bp", vec_seq);
        run_drain("bp", vec_seq, 32'b10_0010, 1'b0, 10);

        // Busy input: second vector presented throughout the first drain.
        offer("busy1", vec_seq);
        bus.in_data = vec_ones;
        run_drain("busy1", vec_seq, 32'h0, 1'b1, 8);
        @(negedge clk);
        run_drain("busy2", vec_ones, 32'h0, 1'b0, 8);

        // Full-scale lanes with bit 16 set on every beat.
        offer("full", vec_alt);
        run_drain("full", vec_alt, 32'h0, 1'b0, 8);

        // Reset mid-drain after lane 3 has been accepted.
        offer("rstmid", vec_seq);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) bus.in_valid = 1'b0;
            check($sformatf("rstmid pre lane%0d", k), 32'(bus.out_lane), 32'(k));
            @(negedge clk);
        end
        check("rstmid lane4 shown", 32'(bus.out_lane), 32'd4);
        #2 reset = 1'b0;
        #1;
        check("rstmid async out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid async out_lane", 32'(bus.out_lane), 32'd0);
        check("rstmid async in_ready", 32'(bus.in_ready), 32'd1);
        check("rstmid async out_data", 32'(bus.out_data), 32'd0);
        check("rstmid async out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        offer("rstpost", vec_alt);
        run_drain("rstpost", vec_alt, 32'h0, 1'b0, 8);

        // Back-to-back: three vectors with in_valid held continuously.
        beat_total = 0;
        start_cyc  = cyc;
        offer("b2b0", vec_seq);
        run_drain("b2b0", vec_seq, 32'h0, 1'b1, 8);
        offer("b2b1", vec_ones);
        run_drain("b2b1", vec_ones, 32'h0, 1'b1, 8);
        offer("b2b2", vec_alt);
        run_drain("b2b2", vec_alt, 32'h0, 1'b0, 8);
        check("b2b beats", 32'(beat_total), 32'd24);
        check("b2b cycles", 32'(cyc - start_cyc), 32'd27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
